rotate_right_seq: RTL and testbench
===================================

Name: rotate_right_seq

Overview:
- Iterative 32-bit rotate-right unit for the RV32M accelerator datapath.
- Inverse direction of the byte-granular rotate-left stage. It re-aligns rotated partial results by any amount from 0 to 31 bits.
- Sits between the operand-staging logic and result writeback, with a valid/ready handshake on both sides.
- Uses one shared rotator that applies byte steps and single-bit steps, one per cycle.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- AMT_W, 5, rotate-amount width (log2 XLEN).

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_n_i  input  1  asynchronous reset, active-low.
- valid_i  input  1  request valid.
- ready_o  output  1  unit can accept a request (state IDLE).
- operand_i  input  32  value to rotate.
- amount_i  input  5  rotate-right amount in bits.
- valid_o  output  1  result valid (state DONE).
- ready_i  input  1  consumer accepts result.
- result_o  output  32  rotated value.
- busy_o  output  1  state BUSY.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: state=IDLE, data_q=0, rem_q=0.
  - Outputs during reset: ready_o=1, valid_o=0, busy_o=0, result_o=0.
- States: IDLE, BUSY, DONE. All outputs are decoded from registered state only; no combinational input-to-output path.
- ready_o=1 only in IDLE. valid_o=1 only in DONE. result_o=data_q at all times.
- IDLE:
  - Accept when valid_i && ready_o: data_q<=operand_i, rem_q<=amount_i, next state BUSY.
  - Without valid_i, stay in IDLE.
- BUSY, one action per edge:
  - rem_q==0: go to DONE.
  - rem_q>=8: data_q<=ror8(data_q), rem_q<=rem_q-8.
  - Otherwise: data_q<=ror1(data_q), rem_q<=rem_q-1.
- DONE:
  - Hold result_o and valid_o until ready_i=1.
  - On valid_o && ready_i, go to IDLE.
  - No new request is accepted in the same cycle as the result handoff. ready_o rises in the following cycle.
- Latency:
  - Step count N = amount[4:3] + amount[2:0].
  - valid_o rises N+1 edges after the accepting edge.
  - amount=0 gives 1 edge. amount=31 gives 11 edges.
- Rotation is modulo 32; bits shifted out of bit 0 enter bit 31. The result never depends on operand_i/amount_i after the accepting edge.
- valid_i is ignored while BUSY or DONE. Changes on operand_i/amount_i then have no effect.
- Reset asserted mid-operation returns to IDLE immediately. The in-flight request is dropped and valid_o is not asserted.
- Throughput: at most one request per N+3 cycles (IDLE, then BUSY, then DONE).

Optional Feature:
- Macro: ROTR_BYTE_FASTPATH_EN.
- Defined:
  - On accept, data_q<=ror(operand_i, 8*amount_i[4:3]) through a 4-way byte mux, and rem_q<=amount_i[2:0].
  - The BUSY loop performs only single-bit steps, so N=amount[2:0].
  - Latency is amount[2:0]+1 edges, maximum 8.
- Undefined:
  - Byte steps are iterated in BUSY as described above, and no byte mux is instantiated.
- Results are identical in both builds; only latency differs.

Test Plan:
- operand=0x12345678, amount=8 → result_o=0x78123456. valid_o 2 edges after accept (macro on: 1).
- operand=0x12345678, amount=12 → result_o=0x67812345. valid_o 6 edges after accept (macro on: 5).
- operand=0xDEADBEEF, amount=0 → result_o=0xDEADBEEF. valid_o 1 edge after accept. busy_o high for exactly 1 cycle.
- operand=0x80000001, amount=31 → result_o=0x00000003. valid_o 11 edges after accept (macro on: 8).
- amount=4, ready_i held low 5 cycles in DONE:
  - valid_o and result_o are stable throughout and ready_o stays 0.
  - The result is consumed on the first ready_i=1; ready_o=1 on the next cycle.
  - A valid_i pulse during BUSY is ignored.
- rst_n_i pulsed low 3 cycles after accepting amount=31:
  - state=IDLE, ready_o=1, result_o=0, and valid_o never asserts for that request.
  - The next request with 0x00000001, amount=1 returns 0x80000000.

Source files
------------

// File: rtl/rotate_right_seq_if.sv
// rotate_right_seq_if
// Request/result handshake bundle for the iterative rotate-right unit.
//
// Signals (names are from the unit's point of view):
//   valid_i   - request valid
//   ready_o   - unit can accept a request
//   operand_i - value to rotate (XLEN bits)
//   amount_i  - rotate-right amount in bits (AMT_W bits)
//   valid_o   - result valid
//   ready_i   - consumer accepts result
//   result_o  - rotated value (XLEN bits)
//   busy_o    - unit is iterating
//
// Modports:
//   master - requester/consumer side (drives valid_i, operand_i, amount_i, ready_i)
//   slave  - the rotate unit itself
interface rotate_right_seq_if #(
   parameter int XLEN  = 32,
   parameter int AMT_W = 5
);
   logic             valid_i;
   logic             ready_o;
   logic [XLEN-1:0]  operand_i;
   logic [AMT_W-1:0] amount_i;
   logic             valid_o;
   logic             ready_i;
   logic [XLEN-1:0]  result_o;
   logic             busy_o;

   modport master (
      output valid_i, operand_i, amount_i, ready_i,
      input  ready_o, valid_o, result_o, busy_o
   );

   modport slave (
      input  valid_i, operand_i, amount_i, ready_i,
      output ready_o, valid_o, result_o, busy_o
   );
endinterface

// File: rtl/rotate_right_seq.sv
// rotate_right_seq
// Iterative 32-bit rotate-right unit. A single shared rotator applies one
// byte step (ror 8) or one single-bit step (ror 1) per clock until the
// requested amount is used up, then presents the result until consumed.
//
// Ports:
//   clk_i   - clock, rising edge
//   rst_n_i - asynchronous reset, active low
//   bus     - rotate_right_seq_if.slave handshake bundle
//             (valid_i/ready_o request side, valid_o/ready_i result side,
//              operand_i, amount_i, result_o, busy_o)
//
// Parameters:
//   XLEN  - operand/result width (only 32 is supported)
//   AMT_W - rotate amount width (log2 XLEN)
//
// Build option:
//   ROTR_BYTE_FASTPATH_EN - when defined, the whole-byte part of the amount
//   is applied on accept through a 4-way byte mux, so the iteration only
//   performs single-bit steps (latency amount[2:0]+1). Results are identical
//   in both builds; only latency differs.
module rotate_right_seq #(
   parameter int XLEN  = 32,
   parameter int AMT_W = 5
) (
   input logic                clk_i,
   input logic                rst_n_i,
   rotate_right_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [XLEN-1:0]  data_q;
   logic [XLEN-1:0]  data_d;
   logic [AMT_W-1:0] rem_q;
   logic [AMT_W-1:0] rem_d;

`ifdef ROTR_BYTE_FASTPATH_EN
   logic [XLEN-1:0]  byte_rot;

   // Byte-granular pre-rotation of the incoming operand by 8*amount[4:3];
   // only the remaining 0..7 single-bit steps are left for the loop.
   always_comb begin
      byte_rot = bus.operand_i;
      case (bus.amount_i[4:3])
         2'd0:    byte_rot = bus.operand_i;
         2'd1:    byte_rot = {bus.operand_i[7:0],  bus.operand_i[XLEN-1:8]};
         2'd2:    byte_rot = {bus.operand_i[15:0], bus.operand_i[XLEN-1:16]};
         default: byte_rot = {bus.operand_i[23:0], bus.operand_i[XLEN-1:24]};
      endcase
   end
`endif

   // State, data and remaining-amount registers. Reset clears the data so
   // result_o reads zero after any reset, including one mid-operation.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         data_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
      end
   end

   // Next-state and datapath decisions. In BUSY the larger step is always
   // preferred, so the step count is amount[4:3] + amount[2:0]. Operand and
   // amount are only sampled on the accepting edge.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (bus.valid_i) begin
               state_d = BUSY;
`ifdef ROTR_BYTE_FASTPATH_EN
               data_d  = byte_rot;
               rem_d   = {{(AMT_W-3){1'b0}}, bus.amount_i[2:0]};
`else
               data_d  = bus.operand_i;
               rem_d   = bus.amount_i;
`endif
            end
         end
         BUSY: begin
            if (rem_q == '0) begin
               state_d = DONE;
            end else if (rem_q >= AMT_W'(8)) begin
               data_d = {data_q[7:0], data_q[XLEN-1:8]};
               rem_d  = rem_q - AMT_W'(8);
            end else begin
               data_d = {data_q[0], data_q[XLEN-1:1]};
               rem_d  = rem_q - AMT_W'(1);
            end
         end
         DONE: begin
            if (bus.ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode registered state only, so there is no input-to-output
   // path; ready_o therefore rises one cycle after the result handoff.
   assign bus.ready_o  = (state_q == IDLE);
   assign bus.busy_o   = (state_q == BUSY);
   assign bus.valid_o  = (state_q == DONE);
   assign bus.result_o = data_q;

endmodule

// File: tb/tb_rotate_right_seq.sv
// tb_rotate_right_seq
// Self-checking bench for rotate_right_seq. A timeline model (accept time,
// expected latency, expected rotated value) is checked against the DUT on
// every falling edge; directed vectors additionally pin latency, busy time
// and results against hand-computed literals.
module tb_rotate_right_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int tests  = 0;
   int failed = 0;

   rotate_right_seq_if #(.XLEN(32), .AMT_W(5)) bus ();

   rotate_right_seq #(.XLEN(32), .AMT_W(5)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus.slave)
   );

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   // Guard against a hung handshake
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference rotate: take the low word of the doubled operand shifted right
   function automatic logic [31:0] model_ror(input logic [31:0] op, input logic [4:0] amt);
      logic [63:0] twice;
      twice = {op, op} >> amt;
      return twice[31:0];
   endfunction

   // Edges from accept to valid_o
   function automatic int model_latency(input logic [4:0] amt);
`ifdef ROTR_BYTE_FASTPATH_EN
      return int'(amt % 8) + 1;
`else
      return int'(amt / 8) + int'(amt % 8) + 1;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failed++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // Timeline model: a request is in flight from its accepting edge until the
   // handoff edge; its result is due `lat` edges after acceptance.
   logic        in_flight = 1'b0;
   int          since     = 0;
   int          lat       = 0;
   logic [31:0] exp_res   = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_flight <= 1'b0;
         since     <= 0;
         lat       <= 0;
         exp_res   <= '0;
      end else if (!in_flight) begin
         if (bus.valid_i) begin
            in_flight <= 1'b1;
            since     <= 0;
            lat       <= model_latency(bus.amount_i);
            exp_res   <= model_ror(bus.operand_i, bus.amount_i);
         end
      end else if (since >= lat) begin
         if (bus.ready_i) in_flight <= 1'b0;
      end else begin
         since <= since + 1;
      end
   end

   // Continuous compare against the model on every falling edge
   always @(negedge clk) begin
      logic exp_valid;
      exp_valid = in_flight && (since >= lat);
      checkOutput("model ready_o", 32'(bus.ready_o), 32'(!in_flight));
      checkOutput("model valid_o", 32'(bus.valid_o), 32'(exp_valid));
      checkOutput("model busy_o",  32'(bus.busy_o),  32'(in_flight && !exp_valid));
      if (!in_flight || exp_valid)
         checkOutput("model result_o", bus.result_o, exp_res);
   end

   // One directed request: accept, wait for valid_o (bounded), optionally
   // stall the consumer and inject a stray valid_i while busy, then consume.
   task automatic applyStimulus(input logic [31:0] op, input logic [4:0] amt,
                                input logic [31:0] lit_res, input int lit_lat,
                                input int hold, input bit pulse);
      int edges;
      int busy_cycles;
      bit got;
      edges       = 0;
      busy_cycles = 0;
      got         = 1'b0;
      @(posedge clk); #1;
      checkOutput("ready before accept", 32'(bus.ready_o), 32'd1);
      bus.valid_i   = 1'b1;
      bus.operand_i = op;
      bus.amount_i  = amt;
      @(posedge clk); #1;
      bus.valid_i   = 1'b0;
      bus.operand_i = ~op;
      bus.amount_i  = ~amt;
      for (int i = 0; i < 40 && !got; i++) begin
         if (bus.busy_o) busy_cycles++;
         if (pulse && i == 0) begin
            bus.valid_i   = 1'b1;
            bus.operand_i = 32'hFFFF_FFFF;
            bus.amount_i  = 5'd3;
         end
         @(posedge clk); #1;
         bus.valid_i = 1'b0;
         edges++;
         if (bus.valid_o) got = 1'b1;
      end
      checkOutput("valid_o arrived", 32'(got), 32'd1);
      checkOutput("latency", 32'(edges), 32'(lit_lat));
      checkOutput("busy cycles", 32'(busy_cycles), 32'(lit_lat));
      checkOutput("result", bus.result_o, lit_res);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         checkOutput("stall valid_o", 32'(bus.valid_o), 32'd1);
         checkOutput("stall result", bus.result_o, lit_res);
         checkOutput("stall ready_o", 32'(bus.ready_o), 32'd0);
      end
      bus.ready_i = 1'b1;
      @(posedge clk); #1;
      bus.ready_i = 1'b0;
      checkOutput("post handoff ready_o", 32'(bus.ready_o), 32'd1);
      checkOutput("post handoff valid_o", 32'(bus.valid_o), 32'd0);
   endtask

   initial begin
      bit seen;
      bus.valid_i   = 1'b0;
      bus.ready_i   = 1'b0;
      bus.operand_i = '0;
      bus.amount_i  = '0;

      #2;
      checkOutput("reset ready_o",  32'(bus.ready_o), 32'd1);
      checkOutput("reset valid_o",  32'(bus.valid_o), 32'd0);
      checkOutput("reset busy_o",   32'(bus.busy_o),  32'd0);
      checkOutput("reset result_o", bus.result_o,     32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

`ifdef ROTR_BYTE_FASTPATH_EN
      applyStimulus(32'h1234_5678, 5'd8,  32'h7812_3456, 1, 0, 1'b0);
      applyStimulus(32'h1234_5678, 5'd12, 32'h6781_2345, 5, 0, 1'b0);
      applyStimulus(32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1, 0, 1'b0);
      applyStimulus(32'h8000_0001, 5'd31, 32'h0000_0003, 8, 0, 1'b0);
      applyStimulus(32'hA5A5_A5A5, 5'd17, 32'hD2D2_D2D2, 2, 0, 1'b0);
`else
      applyStimulus(32'h1234_5678, 5'd8,  32'h7812_3456, 2, 0, 1'b0);
      applyStimulus(32'h1234_5678, 5'd12, 32'h6781_2345, 6, 0, 1'b0);
      applyStimulus(32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1, 0, 1'b0);
      applyStimulus(32'h8000_0001, 5'd31, 32'h0000_0003, 11, 0, 1'b0);
      applyStimulus(32'hA5A5_A5A5, 5'd17, 32'hD2D2_D2D2, 4, 0, 1'b0);
`endif
      // Consumer stall plus a stray request while busy
      applyStimulus(32'h0000_000F, 5'd4, 32'hF000_0000, 5, 5, 1'b1);

      // Reset in the middle of a long rotate drops the request
      @(posedge clk); #1;
      bus.valid_i   = 1'b1;
      bus.operand_i = 32'h8000_0001;
      bus.amount_i  = 5'd31;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("mid reset ready_o",  32'(bus.ready_o), 32'd1);
      checkOutput("mid reset result_o", bus.result_o,     32'd0);
      checkOutput("mid reset valid_o",  32'(bus.valid_o), 32'd0);
      checkOutput("mid reset busy_o",   32'(bus.busy_o),  32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (bus.valid_o) seen = 1'b1;
      end
      checkOutput("dropped request valid_o", 32'(seen), 32'd0);
      applyStimulus(32'h0000_0001, 5'd1, 32'h8000_0000, 2, 0, 1'b0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
